// File: rtl/multi_edge_pulse_pkg.sv
// Shared constants for the multi-channel edge/pulse converter.
// Mode encoding, repeat FSM states and a small parameter helper.
package multi_edge_pulse_pkg;

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } rpt_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/edge_pulse_channel.sv
// One input channel: 2-flop synchroniser, debounce filter,
// edge detection with mode select and an auto-repeat FSM.
module edge_pulse_channel
    import multi_edge_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 100
) (
    input  logic       clock,
    input  logic       globalReset_n,
    input  logic       level,
    input  logic [1:0] mode,
    input  logic       repeat_en,
    output logic       pulse,
    output logic       pulse_next,
    output logic       level_out
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD);
    localparam logic [RW-1:0] R_ONE    = RW'(1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          level_q;

    rpt_state_t    state, state_d;
    logic [RW-1:0] rcnt, rcnt_d;

    logic rise, fall;
    logic rise_en, fall_en;
    logic rpt_fire;
    logic abort;

    always_ff @(posedge clock) begin
        if (!globalReset_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            cnt       <= '0;
            level_out <= 1'b0;
            level_q   <= 1'b0;
        end else begin
            sync1   <= level;
            sync2   <= sync1;
            level_q <= level_out;
            if (sync2 == level_out) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level_out <= sync2;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise    = level_out & ~level_q;
    assign fall    = ~level_out & level_q;
    assign rise_en = rise & ((mode == MODE_RISE) | (mode == MODE_BOTH));
    assign fall_en = fall & ((mode == MODE_FALL) | (mode == MODE_BOTH));

    // Leaving HOLD/REPEAT on release also swallows a coincident expiry.
    assign abort = ~level_out | ~repeat_en
                 | (mode == MODE_FALL) | (mode == MODE_OFF);

    always_comb begin
        state_d  = state;
        rcnt_d   = rcnt;
        rpt_fire = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rise_en && repeat_en) begin
                    state_d = ST_HOLD;
                    rcnt_d  = R_ONE;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    rcnt_d  = '0;
                end else if (rcnt == R_DELAY) begin
                    rpt_fire = 1'b1;
                    state_d  = ST_REPEAT;
                    rcnt_d   = R_ONE;
                end else begin
                    rcnt_d = rcnt + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    rcnt_d  = '0;
                end else if (rcnt == R_PERIOD) begin
                    rpt_fire = 1'b1;
                    rcnt_d   = R_ONE;
                end else begin
                    rcnt_d = rcnt + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rcnt_d  = '0;
            end
        endcase
    end

    assign pulse_next = rise_en | fall_en | rpt_fire;

    always_ff @(posedge clock) begin
        if (!globalReset_n) begin
            state <= ST_IDLE;
            rcnt  <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_d;
            rcnt  <= rcnt_d;
            pulse <= pulse_next;
        end
    end

endmodule

// File: rtl/multi_edge_pulse.sv
// Multi-channel level-to-pulse converter with debounce and
// auto-repeat; one edge_pulse_channel per input plus any_pulse.
module multi_edge_pulse
    import multi_edge_pulse_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 100
) (
    input  logic                  clock,
    input  logic                  globalReset_n,
    input  logic [CHANNELS-1:0]   level,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   repeat_en,
    output logic [CHANNELS-1:0]   pulse,
    output logic [CHANNELS-1:0]   level_out,
    output logic                  any_pulse
);

    logic [CHANNELS-1:0] pulse_next;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        edge_pulse_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clock        (clock),
            .globalReset_n(globalReset_n),
            .level        (level[i]),
            .mode         (mode[2*i+1:2*i]),
            .repeat_en    (repeat_en[i]),
            .pulse        (pulse[i]),
            .pulse_next   (pulse_next[i]),
            .level_out    (level_out[i])
        );
    end

    // Built from next-state pulses so it lines up with the pulse register.
    always_ff @(posedge clock) begin
        if (!globalReset_n) begin
            any_pulse <= 1'b0;
        end else begin
            any_pulse <= |pulse_next;
        end
    end

endmodule
